// File: rtl/fp_normalize_pipe.sv
// Post-add/sub FP normaliser: 2-cycle latency, 1 beat/cycle sustained.
// Stalls hold output regs; in_ready is combinational from out_ready so a full pipe still streams.
module fp_normalize_pipe #(
    parameter int MAN_W = 24,
    parameter int EXP_W = 8,
    localparam int SHW = $clog2(MAN_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [MAN_W-1:0] in_mantissa,
    input  logic             in_carry,
    input  logic             in_sub,
    input  logic [EXP_W-1:0] in_exp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [MAN_W-2:0] out_fraction,
    output logic [EXP_W-1:0] out_exp,
    output logic [SHW-1:0]   out_shift,
    output logic             out_zero,
    output logic             out_underflow,
    output logic             out_overflow
);

    localparam int CW = (SHW > EXP_W) ? SHW : EXP_W;

    // Stage 1 state
    logic             s1_vld_q;
    logic [MAN_W-1:0] s1_man_q;
    logic             s1_carry_q;
    logic             s1_sub_q;
    logic [EXP_W-1:0] s1_exp_q;
    logic [SHW-1:0]   s1_lz_q;
    logic [SHW-1:0]   lz_d;

    // Stage 2 (output) state
    logic             out_vld_q;
    logic [MAN_W-2:0] frac_q, frac_d;
    logic [EXP_W-1:0] exp_q, exp_d;
    logic [SHW-1:0]   shift_q, shift_d;
    logic             zero_q, zero_d;
    logic             unf_q, unf_d;
    logic             ovf_q, ovf_d;

    logic adv2;

    assign adv2     = !out_vld_q || out_ready;
    assign in_ready = !s1_vld_q || adv2;

    // Ascending scan: the highest set bit is the last to write, so it wins.
    always_comb begin
        lz_d = '0;
        for (int i = 0; i < MAN_W; i++) begin
            if (in_mantissa[i]) begin
                lz_d = SHW'(MAN_W - 1 - i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q   <= 1'b0;
            s1_man_q   <= '0;
            s1_carry_q <= 1'b0;
            s1_sub_q   <= 1'b0;
            s1_exp_q   <= '0;
            s1_lz_q    <= '0;
        end else begin
            if (in_ready) begin
                s1_vld_q <= in_valid;
            end
            if (in_valid && in_ready) begin
                s1_man_q   <= in_mantissa;
                s1_carry_q <= in_carry;
                s1_sub_q   <= in_sub;
                s1_exp_q   <= in_exp;
                s1_lz_q    <= lz_d;
            end
        end
    end

    // Carry path: the fraction after the right shift is mantissa[MAN_W-1:1];
    // the hidden one is implicit, so a round-up that wraps the fraction means
    // the significand overflowed to 10.0 and the exponent takes a second +1.
    logic             carry_path;
    logic             rnd;
    logic             wrap;
    logic [MAN_W-2:0] frac_c;
    logic [EXP_W:0]   exp_c;
    logic             man_zero;
    logic             lz_unf;

    always_comb begin
        carry_path = !s1_sub_q && s1_carry_q;
        rnd        = s1_man_q[0] && s1_man_q[1];
        wrap       = rnd && (&s1_man_q[MAN_W-1:1]);
        frac_c     = s1_man_q[MAN_W-1:1] + (MAN_W-1)'(rnd);
        exp_c      = {1'b0, s1_exp_q} + (wrap ? (EXP_W+1)'(2) : (EXP_W+1)'(1));
        man_zero   = (s1_man_q == '0);
        lz_unf     = (CW'(s1_lz_q) >= CW'(s1_exp_q));

        frac_d  = '0;
        exp_d   = '0;
        shift_d = '0;
        zero_d  = 1'b0;
        unf_d   = 1'b0;
        ovf_d   = 1'b0;

        if (carry_path) begin
            if (exp_c >= {1'b0, {EXP_W{1'b1}}}) begin
                ovf_d = 1'b1;
                exp_d = '1;
            end else begin
                frac_d = frac_c;
                exp_d  = exp_c[EXP_W-1:0];
            end
        end else if (man_zero) begin
            zero_d = 1'b1;
        end else begin
            shift_d = s1_lz_q;
            if (lz_unf) begin
                unf_d = 1'b1;
            end else begin
                // The leading one shifts out of the top, leaving only the fraction.
                frac_d = s1_man_q[MAN_W-2:0] << s1_lz_q;
                exp_d  = s1_exp_q - EXP_W'(s1_lz_q);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld_q <= 1'b0;
            frac_q    <= '0;
            exp_q     <= '0;
            shift_q   <= '0;
            zero_q    <= 1'b0;
            unf_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else if (adv2) begin
            out_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                frac_q  <= frac_d;
                exp_q   <= exp_d;
                shift_q <= shift_d;
                zero_q  <= zero_d;
                unf_q   <= unf_d;
                ovf_q   <= ovf_d;
            end
        end
    end

    assign out_valid     = out_vld_q;
    assign out_fraction  = frac_q;
    assign out_exp       = exp_q;
    assign out_shift     = shift_q;
    assign out_zero      = zero_q;
    assign out_underflow = unf_q;
    assign out_overflow  = ovf_q;

endmodule

// File: tb/tb_fp_normalize_pipe.sv
// Bench for fp_normalize_pipe: directed cases, backpressure, async reset, then random traffic
// scored against an arithmetic reference model.
module tb_fp_normalize_pipe;

    localparam int MAN_W = 24;
    localparam int EXP_W = 8;
    localparam int SHW   = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [MAN_W-1:0] in_mantissa;
    logic             in_carry;
    logic             in_sub;
    logic [EXP_W-1:0] in_exp;
    logic             out_valid;
    logic             out_ready;
    logic [MAN_W-2:0] out_fraction;
    logic [EXP_W-1:0] out_exp;
    logic [SHW-1:0]   out_shift;
    logic             out_zero;
    logic             out_underflow;
    logic             out_overflow;

    always #5 clk = ~clk;

    fp_normalize_pipe #(.MAN_W(MAN_W), .EXP_W(EXP_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_mantissa   (in_mantissa),
        .in_carry      (in_carry),
        .in_sub        (in_sub),
        .in_exp        (in_exp),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_fraction  (out_fraction),
        .out_exp       (out_exp),
        .out_shift     (out_shift),
        .out_zero      (out_zero),
        .out_underflow (out_underflow),
        .out_overflow  (out_overflow)
    );

    typedef struct packed {
        logic [22:0] frac;
        logic [7:0]  exp;
        logic [4:0]  shift;
        logic        zero;
        logic        unf;
        logic        ovf;
    } res_t;

    res_t q[$];
    int   checks = 0;
    int   errors = 0;
    logic acc    = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Real-number view: value = 1.fraction * 2^exp, worked with plain integers.
    function automatic res_t model(input logic [23:0] m, input logic c, input logic s,
                                   input logic [7:0] e);
        res_t   r;
        longint v;
        longint ex;
        int     lz;
        r = '0;
        if (!s && c) begin
            v = (longint'(m) + (longint'(1) << 24)) / 2;
            if ((m % 2 == 1) && (v % 2 == 1)) v = v + 1;
            if (v >= (longint'(1) << 24)) begin
                ex = longint'(e) + 2;
            end else begin
                ex = longint'(e) + 1;
                r.frac = 23'(v - (longint'(1) << 23));
            end
            if (ex >= 255) begin
                r.ovf  = 1'b1;
                r.exp  = 8'hFF;
                r.frac = '0;
            end else begin
                r.exp = 8'(ex);
            end
        end else if (m == 0) begin
            r.zero = 1'b1;
        end else begin
            v  = longint'(m);
            lz = 0;
            while (v < (longint'(1) << 23)) begin
                v  = v * 2;
                lz = lz + 1;
            end
            r.shift = 5'(lz);
            if (lz >= int'(e)) begin
                r.unf = 1'b1;
            end else begin
                r.frac = 23'(v - (longint'(1) << 23));
                r.exp  = 8'(int'(e) - lz);
            end
        end
        return r;
    endfunction

    // One clock: observe handshakes at the falling edge, then step past the rising edge.
    task automatic tick();
        res_t r;
        @(negedge clk);
        acc = in_valid && in_ready;
        if (out_valid) begin
            if (q.size() == 0) begin
                check("spurious_out", 1, 0);
            end else begin
                r = q[0];
                check("frac", 64'(out_fraction), 64'(r.frac));
                check("exp", 64'(out_exp), 64'(r.exp));
                check("shift", 64'(out_shift), 64'(r.shift));
                check("flags", 64'({out_zero, out_underflow, out_overflow}),
                      64'({r.zero, r.unf, r.ovf}));
                if (out_ready) r = q.pop_front();
            end
        end
        if (acc) q.push_back(model(in_mantissa, in_carry, in_sub, in_exp));
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [23:0] m, input logic c, input logic s, input logic [7:0] e);
        in_mantissa = m;
        in_carry    = c;
        in_sub      = s;
        in_exp      = e;
        in_valid    = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (acc) break;
        end
        if (!acc) check("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            if (q.size() == 0) break;
            tick();
        end
        check("drain_left", 64'(q.size()), 0);
    endtask

    task automatic gen_beat();
        logic [7:0] e;
        case ($urandom_range(0, 3))
            0:       e = 8'($urandom_range(0, 3));
            1:       e = 8'($urandom_range(252, 255));
            default: e = 8'($urandom_range(0, 255));
        endcase
        in_exp = e;
        case ($urandom_range(0, 4))
            0: begin in_mantissa = 24'($urandom); in_carry = 1'b1; in_sub = 1'b0; end
            1: begin
                in_mantissa = 24'($urandom) >> $urandom_range(0, 23);
                in_carry    = 1'($urandom);
                in_sub      = 1'b1;
            end
            2: begin in_mantissa = '0; in_carry = 1'b0; in_sub = 1'($urandom); end
            3: begin
                in_mantissa = ($urandom_range(0, 1) == 1) ? 24'hFFFFFF : (24'($urandom) | 24'h3);
                in_carry    = 1'b1;
                in_sub      = 1'b0;
            end
            default: begin
                in_mantissa = 24'($urandom);
                in_carry    = 1'($urandom);
                in_sub      = 1'($urandom);
            end
        endcase
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_mantissa = '0;
        in_carry    = 1'b0;
        in_sub      = 1'b0;
        in_exp      = '0;
        out_ready   = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 0);
        check("rst_outs", 64'({out_fraction, out_exp, out_shift, out_zero, out_underflow,
                              out_overflow}), 0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 1);

        // Normalised input passes through; latency check on the way.
        out_ready = 1'b1;
        send(24'h800000, 1'b0, 1'b1, 8'h7F);
        check("lat_cycle1", 64'(out_valid), 0);
        tick();
        check("lat_cycle2", 64'(out_valid), 1);
        drain();

        send(24'h000F00, 1'b0, 1'b1, 8'h80);
        drain();
        send(24'h000003, 1'b1, 1'b0, 8'h10);
        send(24'hFFFFFF, 1'b1, 1'b0, 8'h10);
        send(24'hFFFFFF, 1'b1, 1'b0, 8'hFD);
        send(24'h000010, 1'b0, 1'b1, 8'h05);
        send(24'h000000, 1'b0, 1'b1, 8'h40);
        drain();

        // Backpressure: two beats fill the pipe, the third must wait.
        out_ready = 1'b0;
        send(24'h123456, 1'b0, 1'b1, 8'h30);
        send(24'h00ABCD, 1'b1, 1'b0, 8'h31);
        in_mantissa = 24'h000777;
        in_carry    = 1'b0;
        in_sub      = 1'b1;
        in_exp      = 8'h32;
        in_valid    = 1'b1;
        check("full_in_ready", 64'(in_ready), 0);
        repeat (2) begin
            tick();
            check("stall_no_accept", 64'(acc), 0);
            check("stall_out_valid", 64'(out_valid), 1);
        end
        out_ready = 1'b1;
        send(24'h000777, 1'b0, 1'b1, 8'h32);
        drain();

        // Asynchronous reset with two beats in flight.
        out_ready = 1'b0;
        send(24'h0F0000, 1'b0, 1'b1, 8'h20);
        send(24'h00F000, 1'b0, 1'b1, 8'h20);
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", 64'(out_valid), 0);
        check("arst_in_ready", 64'(in_ready), 1);
        q.delete();
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (5) tick();
        check("post_rst_out_valid", 64'(out_valid), 0);

        // Random traffic with random backpressure; input held until accepted.
        in_valid = 1'b0;
        acc      = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (!in_valid || acc) begin
                if ($urandom_range(0, 9) < 7) begin
                    gen_beat();
                    in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
